// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and defaults for the bus master controller
package bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_RESP,
    S_GAP
  } mst_state_t;

  localparam logic [7:0] IDLE_ADDR_DEFAULT = 8'h00;

  // Response data is stored at a fixed maximum width; the top narrows it to BUS_WIDTH.
  localparam int RSP_MAX_W = 32;

  typedef struct packed {
    logic [RSP_MAX_W-1:0] rdata;
    logic                 timeout;
    logic                 perr;
  } rsp_t;

endpackage

// File: rtl/bus_if.sv
// rtl/bus_if.sv - slave bus: address, active-low RB/WB/ACK strobes, split data paths
interface bus_if #(
  parameter int BUS_WIDTH = 8
);
  logic [7:0]           addr;
  logic                 rb_n;
  logic                 wb_n;
  logic [BUS_WIDTH-1:0] wdata;
  logic                 wdata_oe;
  logic [BUS_WIDTH-1:0] rdata;
  logic                 parity;
  logic                 ack_n;

  // wdata_oe low means the master has released the data lines.
  modport master (
    output addr, rb_n, wb_n, wdata, wdata_oe,
    input  rdata, parity, ack_n
  );

  modport slave (
    input  addr, rb_n, wb_n, wdata, wdata_oe,
    output rdata, parity, ack_n
  );
endinterface

// File: rtl/bus_timeout_cnt.sv
// rtl/bus_timeout_cnt.sv - ACK wait counter, expired on its last allowed cycle
module bus_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired_o = (cnt_q == LIMIT);
endmodule

// File: rtl/bus_master_ctrl.sv
// rtl/bus_master_ctrl.sv - single-outstanding bus master (IDLE/CMD/RESP/GAP)
// Optional parity check: define BUS_MASTER_PARITY_CHECK_EN.
module bus_master_ctrl
  import bus_pkg::*;
#(
  parameter int         BUS_WIDTH      = 8,
  parameter int         TIMEOUT_CYCLES = 16,
  parameter logic [7:0] IDLE_ADDR      = IDLE_ADDR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [7:0]           req_id,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [BUS_WIDTH-1:0] rsp_rdata,
  output logic                 rsp_timeout,
  output logic                 rsp_perr,
  bus_if.master                bus_m
);
  mst_state_t           state_q;
  logic                 req_ready_q;
  logic                 rsp_valid_q;
  rsp_t                 rsp_q;
  logic                 write_q;
  logic [7:0]           addr_q;
  logic                 rb_n_q;
  logic                 wb_n_q;
  logic [BUS_WIDTH-1:0] wdata_q;
  logic                 wdata_oe_q;
  logic                 tmo_expired;
  logic                 perr_d;

  bus_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (state_q != S_CMD),
    .en_i     (state_q == S_CMD),
    .expired_o(tmo_expired)
  );

`ifdef BUS_MASTER_PARITY_CHECK_EN
  assign perr_d = bus_m.parity != (^(write_q ? wdata_q : bus_m.rdata));
`else
  assign perr_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= IDLE_ADDR;
      rb_n_q      <= 1'b1;
      wb_n_q      <= 1'b1;
      wdata_q     <= '0;
      wdata_oe_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            state_q     <= S_CMD;
            req_ready_q <= 1'b0;
            write_q     <= req_write;
            addr_q      <= req_id;
            rb_n_q      <= req_write;
            wb_n_q      <= !req_write;
            wdata_q     <= req_wdata;
            wdata_oe_q  <= req_write;
          end
        end
        S_CMD: begin
          // ACK is checked first so an ACK on the limit cycle is not a timeout.
          if (!bus_m.ack_n || tmo_expired) begin
            state_q       <= S_RESP;
            rsp_valid_q   <= 1'b1;
            addr_q        <= IDLE_ADDR;
            rb_n_q        <= 1'b1;
            wb_n_q        <= 1'b1;
            wdata_oe_q    <= 1'b0;
            rsp_q.timeout <= bus_m.ack_n;
            rsp_q.perr    <= !bus_m.ack_n && perr_d;
            if (!bus_m.ack_n && !write_q) begin
              rsp_q.rdata <= RSP_MAX_W'(bus_m.rdata);
            end
          end
        end
        S_RESP: begin
          state_q       <= S_GAP;
          rsp_valid_q   <= 1'b0;
          rsp_q.timeout <= 1'b0;
          rsp_q.perr    <= 1'b0;
        end
        S_GAP: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = BUS_WIDTH'(rsp_q.rdata);
  assign rsp_timeout    = rsp_q.timeout;
  assign rsp_perr       = rsp_q.perr;
  assign bus_m.addr     = addr_q;
  assign bus_m.rb_n     = rb_n_q;
  assign bus_m.wb_n     = wb_n_q;
  assign bus_m.wdata    = wdata_q;
  assign bus_m.wdata_oe = wdata_oe_q;
endmodule
